clk_counter_mc: RTL and testbench
=================================

CLK_COUNTER_MC -- requirements
Module: clk_counter_mc

Interface
REQ-001 Parameter WIDTH, default 29: width in bits of each channel counter and of RESULT.
REQ-002 Parameter CHANNELS, default 4: number of independent event-counting channels, legal range 1..16.
REQ-003 Parameter DISP_BITS, default 8: width of the LED display slice, legal range 1..WIDTH.
REQ-004 Parameter GATE_CYCLES, default 100000: length of the gate window in CLK cycles, minimum 2.
REQ-005 Parameter SATURATE, default 0: 0 means counters wrap to zero, 1 means counters hold at all-ones.
REQ-006 CLK  input  1  system clock; all state is clocked on its rising edge.
REQ-007 RESET  input  1  asynchronous, active-high reset.
REQ-008 EV_IN  input  CHANNELS  asynchronous event inputs; one bit per channel, counted on rising edges.
REQ-009 EN  input  1  count enable; 1 counts, 0 freezes counting.
REQ-010 CLR  input  1  synchronous, active-high clear of counters, results and overflow flags.
REQ-011 MODE  input  1  counting mode; 0 is free-run, 1 is gated frequency measurement.
REQ-012 SEL  input  max(1,clog2(CHANNELS))  selects the channel driven onto DISP and RESULT.
REQ-013 DISP  output  DISP_BITS  top DISP_BITS bits of the displayed value for the selected channel.
REQ-014 RESULT  output  WIDTH  full displayed value for the selected channel.
REQ-015 RESULT_VALID  output  1  one-cycle pulse that marks the end of a gate window.
REQ-016 OVF  output  CHANNELS  sticky per-channel overflow flags.

Function
REQ-017 Each EV_IN bit SHALL pass through a 2-flop synchroniser plus rising-edge detector; a detected edge increments its counter on the 3rd CLK rising edge after the input rises.
REQ-018 Edge detection SHALL run continuously; edges arriving while EN=0 are lost and never queued.
REQ-019 Increment rule: with EN=1 and an edge detected, count +1; at all-ones, count becomes 0 when SATURATE=0 or stays all-ones when SATURATE=1; in both cases OVF[ch] is set.
REQ-020 OVF bits SHALL be sticky and clear only on CLR or RESET.
REQ-021 MODE=0: DISP and RESULT SHALL reflect the live counter of channel SEL; the gate counter is held at 0; RESULT_VALID stays 0.
REQ-022 MODE=1 with EN=1: the gate counter counts 0..GATE_CYCLES-1 and wraps.
REQ-023 On the terminal gate cycle, each channel's result register SHALL load the counter value including any edge detected in that cycle, the counter SHALL reload to 0, and RESULT_VALID SHALL pulse high for the following cycle.
REQ-024 MODE=1 with EN=0: the gate counter and the channel counters hold their values.
REQ-025 MODE=1: DISP and RESULT SHALL show the latched result of channel SEL, not the live count.
REQ-026 A change of MODE SHALL zero the gate counter and all channel counters in that cycle; results and OVF are kept.
REQ-027 Priority: RESET over CLR over mode change over gate terminal over increment.
REQ-028 CLR SHALL zero counters, results, gate counter and OVF; an edge in the same cycle is discarded.
REQ-029 If SEL >= CHANNELS, DISP and RESULT SHALL be 0.
REQ-030 DISP, RESULT and OVF SHALL be driven combinationally from registers with no extra latency; RESULT_VALID SHALL be registered.

Reset
REQ-031 Asserting RESET SHALL immediately zero, independently of CLK: all counters, results, the gate counter, synchroniser flops, OVF and RESULT_VALID.
REQ-032 After RESET deasserts, DISP=0 and RESULT=0, and the first gate window starts at gate count 0.
REQ-033 RESET mid-gate SHALL abandon the window with no RESULT_VALID pulse.

Structure
REQ-034 Package clk_counter_pkg SHALL hold the MODE_FREE/MODE_GATED constants and a clog2 function.
REQ-035 Sub-module edge_sync (2-flop synchroniser plus rising-edge pulse) SHALL be instantiated once per channel.
REQ-036 Channel counters, results and OVF SHALL be generated per channel; the gate counter and output mux are shared.

Verification
Common bench parameters: WIDTH=8, CHANNELS=2, DISP_BITS=4, GATE_CYCLES=16.
REQ-037 Reset: RESET pulse mid-activity -> DISP=0, RESULT=0, OVF=00 and RESULT_VALID=0 immediately, without a clock.
REQ-038 Free-run: MODE=0, EN=1, 5 pulses on EV_IN[0], SEL=0 -> RESULT=5 three cycles after the last rise; EN=0 then 3 pulses -> RESULT stays 5.
REQ-039 Overflow: 257 pulses on channel 0 -> SATURATE=0 gives RESULT=1 and OVF=01; SATURATE=1 gives RESULT=255, DISP=F and OVF=01.
REQ-040 Gated: EV_IN[1] toggling every CLK, MODE=1, SEL=1 -> RESULT_VALID pulses every 16 cycles and RESULT=8 after the first full window.
REQ-041 CLR coincident with a detected edge and OVF=1 -> counter 0, OVF cleared, and the next edge gives count 1.
REQ-042 Mode switch at gate count 10 -> gate counter and channel counters go to 0; the next RESULT_VALID comes 16 cycles after the switch.

Source files
------------

// File: rtl/clk_counter_pkg.sv
// Shared constants and helpers for the multi-channel event counter.
package clk_counter_pkg;

    localparam logic MODE_FREE  = 1'b0;
    localparam logic MODE_GATED = 1'b1;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser followed by a single-cycle rising-edge pulse.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise_c
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_c = sync_q & ~prev_q;

endmodule

// File: rtl/clk_counter_mc.sv
// Multi-channel event counter with free-run and gated frequency-measurement modes.
module clk_counter_mc
    import clk_counter_pkg::*;
#(
    parameter int unsigned WIDTH       = 29,
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned DISP_BITS   = 8,
    parameter int unsigned GATE_CYCLES = 100000,
    parameter int unsigned SATURATE    = 0
) (
    input  logic                                                  CLK,
    input  logic                                                  RESET,
    input  logic [CHANNELS-1:0]                                   EV_IN,
    input  logic                                                  EN,
    input  logic                                                  CLR,
    input  logic                                                  MODE,
    input  logic [((CHANNELS > 1) ? clog2(CHANNELS) : 1)-1:0]     SEL,
    output logic [DISP_BITS-1:0]                                  DISP,
    output logic [WIDTH-1:0]                                      RESULT,
    output logic                                                  RESULT_VALID,
    output logic [CHANNELS-1:0]                                   OVF
);

    localparam int unsigned SEL_W  = (CHANNELS > 1) ? clog2(CHANNELS) : 1;
    localparam int unsigned GATE_W = clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [WIDTH-1:0]  CNT_MAX   = '1;

    logic              mode_q;
    logic [GATE_W-1:0] gate_q;
    logic              valid_q;

    logic mode_chg_c;
    logic gate_run_c;
    logic terminal_c;

    logic [CHANNELS-1:0] rise_vec;
    logic [CHANNELS-1:0] ovf_vec;
    logic [WIDTH-1:0]    cnt_arr [CHANNELS];
    logic [WIDTH-1:0]    res_arr [CHANNELS];
    logic [WIDTH-1:0]    shown_c;

    // Shared control: mode change detect and the gate-window terminal cycle.
    always_comb begin
        mode_chg_c = (MODE != mode_q);
        gate_run_c = (MODE == MODE_GATED) && EN;
        terminal_c = !CLR && !mode_chg_c && gate_run_c && (gate_q == GATE_LAST);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mode_q  <= MODE_FREE;
            gate_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            mode_q  <= MODE;
            valid_q <= terminal_c;
            if (CLR || mode_chg_c || (MODE == MODE_FREE)) begin
                gate_q <= '0;
            end else if (terminal_c) begin
                gate_q <= '0;
            end else if (gate_run_c) begin
                gate_q <= gate_q + GATE_W'(1);
            end
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [WIDTH-1:0] cnt_q;
        logic [WIDTH-1:0] res_q;
        logic             ovf_q;
        logic [WIDTH-1:0] inc_c;
        logic [WIDTH-1:0] sum_c;
        logic             hit_c;
        logic             wrap_c;

        edge_sync u_sync (
            .clk      (CLK),
            .rst      (RESET),
            .async_in (EV_IN[ch]),
            .rise_c   (rise_vec[ch])
        );

        // Counter value after this cycle's edge, wrapping or saturating at all-ones.
        always_comb begin
            hit_c  = EN && rise_vec[ch];
            wrap_c = hit_c && (cnt_q == CNT_MAX);
            inc_c  = cnt_q + WIDTH'(1);
            if (cnt_q == CNT_MAX) begin
                inc_c = (SATURATE != 0) ? CNT_MAX : '0;
            end
            sum_c = hit_c ? inc_c : cnt_q;
        end

        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                cnt_q <= '0;
                res_q <= '0;
                ovf_q <= 1'b0;
            end else if (CLR) begin
                cnt_q <= '0;
                res_q <= '0;
                ovf_q <= 1'b0;
            end else if (mode_chg_c) begin
                cnt_q <= '0;
            end else if (terminal_c) begin
                res_q <= sum_c;
                cnt_q <= '0;
                if (wrap_c) begin
                    ovf_q <= 1'b1;
                end
            end else begin
                cnt_q <= sum_c;
                if (wrap_c) begin
                    ovf_q <= 1'b1;
                end
            end
        end

        assign cnt_arr[ch] = cnt_q;
        assign res_arr[ch] = res_q;
        assign ovf_vec[ch] = ovf_q;
    end

    // Display mux: live count in free-run, latched result in gated mode; 0 for absent channels.
    always_comb begin
        shown_c = '0;
        for (int unsigned idx = 0; idx < CHANNELS; idx++) begin
            if (SEL == SEL_W'(idx)) begin
                shown_c = (MODE == MODE_GATED) ? res_arr[idx] : cnt_arr[idx];
            end
        end
    end

    assign RESULT       = shown_c;
    assign DISP         = shown_c[WIDTH-1 -: DISP_BITS];
    assign OVF          = ovf_vec;
    assign RESULT_VALID = valid_q;

endmodule

// File: tb/tb_clk_counter_mc.sv
// Self-checking bench: wrapping and saturating instances driven in parallel.
module tb_clk_counter_mc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en, clr, mode, sel;
    logic       ev0, ev1_man, tog_en;
    logic       tog = 1'b0;
    logic [1:0] ev;

    logic [3:0] disp_w, disp_s;
    logic [7:0] res_w, res_s;
    logic       rv_w, rv_s;
    logic [1:0] ovf_w, ovf_s;

    int n_cmp = 0;
    int n_err = 0;
    int sb_q[$];

    typedef struct {
        int   p0;
        int   p1;
        logic en;
        logic sel;
        int   res;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;
    always @(posedge clk) tog <= tog_en ? ~tog : 1'b0;
    assign ev = {tog_en ? tog : ev1_man, ev0};

    clk_counter_mc #(.WIDTH(8), .CHANNELS(2), .DISP_BITS(4), .GATE_CYCLES(16), .SATURATE(0)) dut_wrap (
        .CLK(clk), .RESET(rst), .EV_IN(ev), .EN(en), .CLR(clr), .MODE(mode), .SEL(sel),
        .DISP(disp_w), .RESULT(res_w), .RESULT_VALID(rv_w), .OVF(ovf_w)
    );

    clk_counter_mc #(.WIDTH(8), .CHANNELS(2), .DISP_BITS(4), .GATE_CYCLES(16), .SATURATE(1)) dut_sat (
        .CLK(clk), .RESET(rst), .EV_IN(ev), .EN(en), .CLR(clr), .MODE(mode), .SEL(sel),
        .DISP(disp_s), .RESULT(res_s), .RESULT_VALID(rv_s), .OVF(ovf_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One-cycle-high pulses on each channel, then enough cycles to drain the synchroniser.
    task automatic pulses(input int p0, input int p1);
        int n;
        n = (p0 > p1) ? p0 : p1;
        for (int i = 0; i < n; i++) begin
            ev0     = (i < p0);
            ev1_man = (i < p1);
            tick();
            ev0     = 1'b0;
            ev1_man = 1'b0;
            tick();
        end
        tick();
        tick();
    endtask

    // Gated-mode sample: scoreboard entry is pushed when a window end is due, popped on RESULT_VALID.
    task automatic rv_sample(input logic exp_rv);
        int exp_res;
        if (exp_rv) sb_q.push_back(8);
        check("rv_wrap", int'(rv_w), int'(exp_rv));
        check("rv_sat", int'(rv_s), int'(exp_rv));
        if (rv_w) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL gate_sb: got unexpected RESULT_VALID, required no pulse at %0t", $time);
            end else begin
                exp_res = sb_q.pop_front();
                check("gate_result_wrap", int'(res_w), exp_res);
                check("gate_result_sat", int'(res_s), exp_res);
            end
        end
    endtask

    initial begin
        int   exp_res;
        logic exp_rv;

        vecs[0] = '{5, 0, 1'b1, 1'b0, 5};
        vecs[1] = '{3, 0, 1'b0, 1'b0, 5};
        vecs[2] = '{0, 2, 1'b1, 1'b1, 2};
        vecs[3] = '{0, 0, 1'b1, 1'b0, 5};
        vecs[4] = '{14, 0, 1'b1, 1'b0, 19};
        vecs[5] = '{0, 20, 1'b0, 1'b1, 2};
        vecs[6] = '{1, 1, 1'b1, 1'b1, 3};
        vecs[7] = '{0, 0, 1'b1, 1'b0, 20};

        en = 1'b0; clr = 1'b0; mode = 1'b0; sel = 1'b0;
        ev0 = 1'b0; ev1_man = 1'b0; tog_en = 1'b0;

        #12;
        check("rst_result", int'(res_w), 0);
        check("rst_disp", int'(disp_s), 0);
        check("rst_ovf", int'(ovf_w), 0);
        check("rst_rv", int'(rv_w), 0);
        rst = 1'b0;
        tick();

        // Free-run table.
        en = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int r = 0; r < 8; r++) begin
            en  = vecs[r].en;
            sel = vecs[r].sel;
            sb_q.push_back(vecs[r].res);
            pulses(vecs[r].p0, vecs[r].p1);
            exp_res = sb_q.pop_front();
            check("free_result_wrap", int'(res_w), exp_res);
            check("free_result_sat", int'(res_s), exp_res);
            check("free_disp", int'(disp_w), exp_res >> 4);
            check("free_ovf", int'(ovf_w), 0);
        end

        // Overflow: 257 edges on channel 0.
        en = 1'b1; sel = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        pulses(257, 0);
        check("ovf_result_wrap", int'(res_w), 1);
        check("ovf_flag_wrap", int'(ovf_w), 1);
        check("ovf_result_sat", int'(res_s), 255);
        check("ovf_disp_sat", int'(disp_s), 15);
        check("ovf_flag_sat", int'(ovf_s), 1);

        // Asynchronous reset with nonzero counts and overflow flags.
        #2 rst = 1'b1;
        #1;
        check("arst_result_wrap", int'(res_w), 0);
        check("arst_result_sat", int'(res_s), 0);
        check("arst_disp_sat", int'(disp_s), 0);
        check("arst_ovf_wrap", int'(ovf_w), 0);
        check("arst_ovf_sat", int'(ovf_s), 0);
        check("arst_rv", int'(rv_w), 0);
        tick();
        rst = 1'b0;
        tick();

        // CLR in the same cycle as a detected edge, with overflow set.
        pulses(257, 0);
        check("pre_clr_ovf", int'(ovf_w), 1);
        ev0 = 1'b1;
        tick();
        ev0 = 1'b0;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_result_wrap", int'(res_w), 0);
        check("clr_result_sat", int'(res_s), 0);
        check("clr_ovf_wrap", int'(ovf_w), 0);
        check("clr_ovf_sat", int'(ovf_s), 0);
        pulses(1, 0);
        check("post_clr_wrap", int'(res_w), 1);
        check("post_clr_sat", int'(res_s), 1);

        // Gated: channel 1 toggling every cycle gives 8 edges per 16-cycle window.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        sel = 1'b1;
        tog_en = 1'b1;
        repeat (4) tick();
        mode = 1'b1;
        for (int k = 1; k <= 59; k++) begin
            tick();
            exp_rv = (k >= 17) && (((k - 17) % 16) == 0);
            rv_sample(exp_rv);
            check("gate_latched", int'(res_w), (k >= 17) ? 8 : 0);
        end

        // Mode switch at gate count 10 and back.
        mode = 1'b0;
        tick();
        check("switch_live_zero", int'(res_w), 0);
        check("switch_rv", int'(rv_w), 0);
        mode = 1'b1;
        tick();
        check("switch_kept", int'(res_w), 8);
        for (int j = 1; j <= 16; j++) begin
            tick();
            rv_sample(j == 16);
        end
        check("sb_drained", sb_q.size(), 0);

        // Reset mid-window abandons it.
        repeat (6) tick();
        #2 rst = 1'b1;
        #1;
        check("mid_rst_rv", int'(rv_w), 0);
        check("mid_rst_result", int'(res_w), 0);
        check("mid_rst_disp", int'(disp_w), 0);
        tick();
        rst = 1'b0;
        for (int j = 0; j < 12; j++) begin
            tick();
            rv_sample(1'b0);
        end
        tog_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
